unidad_carga_almacen: RTL and testbench



---
 rtl/unidad_carga_almacen.sv | 184 ++++++++++++++++++
 tb/tb_unidad_carga_almacen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidad_carga_almacen.sv
// Load/store unit: byte/halfword/word requests to a word-wide data memory, with RMW sub-word stores.
// Optional access counters (NumCargas/NumAlmac) are enabled with `define CONTADORES_ACCESO_EN.
module unidad_carga_almacen #(
   parameter int ANCHO_DIREC = 8,
   parameter int ANCHO_DATO  = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     Inicio,
   input  logic                     Escr,
   input  logic [1:0]               Tam,
   input  logic                     SinSigno,
   input  logic [ANCHO_DIREC+1:0]   DirecByte,
   input  logic [ANCHO_DATO-1:0]    DatoEscr,
   output logic                     Ocupado,
   output logic                     Listo,
   output logic                     ErrAlin,
   output logic [ANCHO_DATO-1:0]    DatoLeido,
   output logic                     EscrMem,
   output logic                     LeerMem,
   output logic [ANCHO_DIREC-1:0]   Direc,
   output logic [ANCHO_DATO-1:0]    Datain,
   input  logic [ANCHO_DATO-1:0]    Dataout,
`ifdef CONTADORES_ACCESO_EN
   output logic [15:0]              NumCargas,
   output logic [15:0]              NumAlmac,
`endif
   output logic [1:0]               estado_dbg_o
);

   // Handshake: a request is taken when Inicio=1 in REPOSO (Ocupado=0); it is complete in
   // the single cycle where Listo=1, and ErrAlin=1 in that same cycle marks a rejected request.

   typedef enum logic [1:0] {
      REPOSO = 2'd0,
      LEER   = 2'd1,
      ESCR   = 2'd2,
      FIN    = 2'd3
   } estado_t;

   estado_t                  estado_q, estado_d;
   logic                     err_q;
   logic                     escr_q;
   logic [1:0]               tam_q;
   logic                     sinsigno_q;
   logic [1:0]               byte_q;
   logic [ANCHO_DIREC-1:0]   dir_q;
   logic [ANCHO_DATO-1:0]    dato_q;
   logic [ANCHO_DATO-1:0]    palabra_q;
   logic [ANCHO_DATO-1:0]    leido_q, leido_d;

   logic                     desalin;
   logic                     acepta;
   logic [7:0]               lane_b;
   logic [15:0]              lane_h;
   logic [ANCHO_DATO-1:0]    extendido;
   logic [ANCHO_DATO-1:0]    fusion;

   always_comb begin
      desalin = 1'b0;
      case (Tam)
         2'b00:   desalin = 1'b0;
         2'b01:   desalin = DirecByte[0];
         2'b10:   desalin = (DirecByte[1:0] != 2'b00);
         default: desalin = 1'b1;
      endcase
   end

   assign acepta = (estado_q == REPOSO) && Inicio && !desalin;

   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         REPOSO: begin
            if (acepta) begin
               estado_d = (Escr && (Tam == 2'b10)) ? ESCR : LEER;
            end
         end
         LEER:    estado_d = escr_q ? ESCR : FIN;
         ESCR:    estado_d = FIN;
         FIN:     estado_d = REPOSO;
         default: estado_d = REPOSO;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q <= REPOSO;
         err_q    <= 1'b0;
      end else begin
         estado_q <= estado_d;
         err_q    <= (estado_q == REPOSO) && Inicio && desalin;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         escr_q     <= 1'b0;
         tam_q      <= 2'b00;
         sinsigno_q <= 1'b0;
         byte_q     <= 2'b00;
         dir_q      <= '0;
         dato_q     <= '0;
      end else if (acepta) begin
         escr_q     <= Escr;
         tam_q      <= Tam;
         sinsigno_q <= SinSigno;
         byte_q     <= DirecByte[1:0];
         dir_q      <= DirecByte[ANCHO_DIREC+1:2];
         dato_q     <= DatoEscr;
      end
   end

   // Little-endian lane extraction straight from the combinational memory read.
   always_comb begin
      lane_b = Dataout[{byte_q, 3'b000} +: 8];
      lane_h = Dataout[{byte_q[1], 4'b0000} +: 16];
      case (tam_q)
         2'b00:   extendido = {{24{lane_b[7] & ~sinsigno_q}}, lane_b};
         2'b01:   extendido = {{16{lane_h[15] & ~sinsigno_q}}, lane_h};
         default: extendido = Dataout;
      endcase
   end

   always_comb begin
      leido_d = leido_q;
      if ((estado_q == LEER) && !escr_q) begin
         leido_d = extendido;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         palabra_q <= '0;
         leido_q   <= '0;
      end else begin
         if (estado_q == LEER) begin
            palabra_q <= Dataout;
         end
         leido_q <= leido_d;
      end
   end

   // Sub-word stores splice the new lane(s) into the word captured in LEER.
   always_comb begin
      fusion = palabra_q;
      case (tam_q)
         2'b00:   fusion[{byte_q, 3'b000} +: 8]     = dato_q[7:0];
         2'b01:   fusion[{byte_q[1], 4'b0000} +: 16] = dato_q[15:0];
         default: fusion = dato_q;
      endcase
   end

   assign Ocupado      = (estado_q != REPOSO);
   assign Listo        = (estado_q == FIN) || err_q;
   assign ErrAlin      = err_q;
   assign LeerMem      = (estado_q == LEER);
   assign EscrMem      = (estado_q == ESCR);
   assign Direc        = dir_q;
   assign Datain       = (estado_q == ESCR) ? fusion : '0;
   assign DatoLeido    = leido_q;
   assign estado_dbg_o = estado_q;

`ifdef CONTADORES_ACCESO_EN
   logic [15:0] num_cargas_q, num_almac_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_cargas_q <= 16'h0000;
         num_almac_q  <= 16'h0000;
      end else if (estado_q == FIN) begin
         if (escr_q) begin
            if (num_almac_q != 16'hFFFF) num_almac_q <= num_almac_q + 16'd1;
         end else begin
            if (num_cargas_q != 16'hFFFF) num_cargas_q <= num_cargas_q + 16'd1;
         end
      end
   end

   assign NumCargas = num_cargas_q;
   assign NumAlmac  = num_almac_q;
`endif

endmodule

// File: tb/tb_unidad_carga_almacen.sv
// Bench for unidad_carga_almacen: directed vector table, hand-written corner sequences and
// random requests checked against a byte-lane memory model.
module tb_unidad_carga_almacen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        Inicio, Escr, SinSigno;
   logic [1:0]  Tam;
   logic [9:0]  DirecByte;
   logic [31:0] DatoEscr;
   logic        Ocupado, Listo, ErrAlin, EscrMem, LeerMem;
   logic [31:0] DatoLeido, Datain, Dataout;
   logic [7:0]  Direc;
   logic [1:0]  estado_dbg;
`ifdef CONTADORES_ACCESO_EN
   logic [15:0] NumCargas, NumAlmac;
`endif

   unidad_carga_almacen #(.ANCHO_DIREC(8), .ANCHO_DATO(32)) dut (
      .clk(clk), .rst_n(rst_n), .Inicio(Inicio), .Escr(Escr), .Tam(Tam),
      .SinSigno(SinSigno), .DirecByte(DirecByte), .DatoEscr(DatoEscr),
      .Ocupado(Ocupado), .Listo(Listo), .ErrAlin(ErrAlin), .DatoLeido(DatoLeido),
      .EscrMem(EscrMem), .LeerMem(LeerMem), .Direc(Direc), .Datain(Datain),
      .Dataout(Dataout),
`ifdef CONTADORES_ACCESO_EN
      .NumCargas(NumCargas), .NumAlmac(NumAlmac),
`endif
      .estado_dbg_o(estado_dbg)
   );

   // clock / memory environment
   always #5 clk = ~clk;

   logic [31:0] mem [256] = '{default: 32'h0};
   assign Dataout = mem[Direc];
   always @(posedge clk) if (EscrMem) mem[Direc] <= Datain;

   // scoreboard and reference model state
   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];
   logic [31:0] ref_mem [256];
   logic [31:0] last_leido;
   int          n_cargas, n_almac;

   int          exp_lat, exp_nl, exp_ne, exp_ciclo_escr;
   logic        exp_err, exp_store;
   logic [31:0] exp_datain;

   int          r_lat, r_nl, r_ne, r_ambos, r_ciclo_escr;
   logic        r_err, r_listo;
   logic [31:0] r_leido, r_datain;
   logic [7:0]  r_direc;

   typedef struct {
      logic        escr;
      logic [1:0]  tam;
      logic        sin;
      logic [9:0]  dir;
      logic [31:0] dato;
      int          lat;
      logic        err;
      logic [31:0] leido;
      logic [31:0] datain;
   } vector_t;

   vector_t tabla [13];

   task automatic comprobar(input string nombre, input logic [31:0] real_v, input logic [31:0] esperado);
      checks++;
      if (real_v !== esperado) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nombre, real_v, esperado);
      end
   endtask

   // Reference model: byte-addressed view of memory built with shifts and masks.
   task automatic modelo(input logic escr, input logic [1:0] tam, input logic sin,
                         input logic [9:0] dir, input logic [31:0] dato);
      int          off, w, nbytes;
      logic [31:0] v, mask;
      off    = int'(dir) % 4;
      w      = int'(dir) / 4;
      nbytes = (tam == 2'd0) ? 1 : (tam == 2'd1) ? 2 : 4;
      exp_store = 1'b0; exp_datain = 32'h0; exp_ciclo_escr = -1;
      if (tam == 2'd3 || (off % nbytes) != 0) begin
         exp_err = 1'b1; exp_lat = 0; exp_nl = 0; exp_ne = 0;
      end else if (!escr) begin
         exp_err = 1'b0; exp_lat = 1; exp_nl = 1; exp_ne = 0;
         v = ref_mem[w] >> (8 * off);
         if (nbytes < 4) begin
            mask = (32'h1 << (8 * nbytes)) - 32'h1;
            v = v & mask;
            if (!sin && v[8 * nbytes - 1]) v = v | ~mask;
         end
         last_leido = v;
         n_cargas++;
      end else begin
         if (nbytes == 4) mask = 32'hFFFF_FFFF;
         else mask = ((32'h1 << (8 * nbytes)) - 32'h1) << (8 * off);
         ref_mem[w] = (ref_mem[w] & ~mask) | ((dato << (8 * off)) & mask);
         exp_datain = ref_mem[w];
         exp_store = 1'b1; exp_err = 1'b0; exp_ne = 1;
         exp_nl  = (nbytes == 4) ? 0 : 1;
         exp_lat = (nbytes == 4) ? 1 : 2;
         exp_ciclo_escr = exp_lat - 1;
         n_almac++;
      end
      exp_q.push_back(last_leido);
   endtask

   // Called at the negedge right after the accepting edge; stops on Listo or after 8 cycles.
   task automatic esperar_fin();
      r_lat = 0; r_nl = 0; r_ne = 0; r_ambos = 0; r_ciclo_escr = -1;
      r_datain = 32'h0; r_direc = 8'h0;
      forever begin
         if (LeerMem) begin r_nl++; r_direc = Direc; end
         if (EscrMem) begin r_ne++; r_direc = Direc; r_datain = Datain; r_ciclo_escr = r_lat; end
         if (LeerMem && EscrMem) r_ambos++;
         if (Listo || r_lat >= 8) break;
         @(negedge clk);
         r_lat++;
      end
      r_listo = Listo; r_err = ErrAlin; r_leido = DatoLeido;
   endtask

   task automatic comparar(input string tag, input logic [9:0] dir);
      logic [31:0] esperado;
      comprobar({tag, "_listo"}, {31'h0, r_listo}, 32'h1);
      comprobar({tag, "_lat"}, r_lat, exp_lat);
      comprobar({tag, "_err"}, {31'h0, r_err}, {31'h0, exp_err});
      if (exp_q.size() == 0) begin
         comprobar({tag, "_queue_empty"}, 32'h1, 32'h0);
      end else begin
         esperado = exp_q.pop_front();
         comprobar({tag, "_leido"}, r_leido, esperado);
      end
      comprobar({tag, "_n_leer"}, r_nl, exp_nl);
      comprobar({tag, "_n_escr"}, r_ne, exp_ne);
      comprobar({tag, "_ambos"}, r_ambos, 0);
      if (exp_store) begin
         comprobar({tag, "_datain"}, r_datain, exp_datain);
         comprobar({tag, "_ciclo_escr"}, r_ciclo_escr, exp_ciclo_escr);
      end
      if (!exp_err) comprobar({tag, "_direc"}, {24'h0, r_direc}, {24'h0, dir[9:2]});
      @(negedge clk);
      comprobar({tag, "_post"}, {27'h0, Listo, ErrAlin, Ocupado, LeerMem, EscrMem}, 32'h0);
   endtask

   task automatic ejecutar(input string tag, input logic escr, input logic [1:0] tam,
                           input logic sin, input logic [9:0] dir, input logic [31:0] dato);
      modelo(escr, tam, sin, dir, dato);
      Inicio = 1'b1; Escr = escr; Tam = tam; SinSigno = sin; DirecByte = dir; DatoEscr = dato;
      @(negedge clk);
      Inicio = 1'b0;
      esperar_fin();
      comparar(tag, dir);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic        r_escr, r_sin;
      logic [1:0]  r_tam;
      logic [9:0]  r_dir;
      int          nb;

      tabla[0]  = '{1'b1, 2'b10, 1'b0, 10'h004, 32'hDEADBEEF, 1, 1'b0, 32'h00000000, 32'hDEADBEEF};
      tabla[1]  = '{1'b0, 2'b10, 1'b0, 10'h004, 32'h00000000, 1, 1'b0, 32'hDEADBEEF, 32'h0};
      tabla[2]  = '{1'b1, 2'b10, 1'b0, 10'h004, 32'h11223344, 1, 1'b0, 32'hDEADBEEF, 32'h11223344};
      tabla[3]  = '{1'b1, 2'b00, 1'b0, 10'h006, 32'h000000AA, 2, 1'b0, 32'hDEADBEEF, 32'h11AA3344};
      tabla[4]  = '{1'b0, 2'b10, 1'b0, 10'h004, 32'h00000000, 1, 1'b0, 32'h11AA3344, 32'h0};
      tabla[5]  = '{1'b1, 2'b10, 1'b0, 10'h008, 32'h000080F0, 1, 1'b0, 32'h11AA3344, 32'h000080F0};
      tabla[6]  = '{1'b0, 2'b00, 1'b0, 10'h008, 32'h00000000, 1, 1'b0, 32'hFFFFFFF0, 32'h0};
      tabla[7]  = '{1'b0, 2'b00, 1'b1, 10'h008, 32'h00000000, 1, 1'b0, 32'h000000F0, 32'h0};
      tabla[8]  = '{1'b0, 2'b01, 1'b0, 10'h008, 32'h00000000, 1, 1'b0, 32'hFFFF80F0, 32'h0};
      tabla[9]  = '{1'b0, 2'b10, 1'b0, 10'h005, 32'h00000000, 0, 1'b1, 32'hFFFF80F0, 32'h0};
      tabla[10] = '{1'b1, 2'b01, 1'b0, 10'h003, 32'h0000BEEF, 0, 1'b1, 32'hFFFF80F0, 32'h0};
      tabla[11] = '{1'b0, 2'b11, 1'b0, 10'h008, 32'h00000000, 0, 1'b1, 32'hFFFF80F0, 32'h0};
      tabla[12] = '{1'b0, 2'b01, 1'b1, 10'h00A, 32'h00000000, 1, 1'b0, 32'h00000000, 32'h0};

      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
      last_leido = 32'h0; n_cargas = 0; n_almac = 0;

      // reset
      rst_n = 1'b0; Inicio = 1'b0; Escr = 1'b0; Tam = 2'b00; SinSigno = 1'b0;
      DirecByte = 10'h0; DatoEscr = 32'h0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      comprobar("reset_ctrl", {27'h0, Ocupado, Listo, ErrAlin, LeerMem, EscrMem}, 32'h0);
      comprobar("reset_leido", DatoLeido, 32'h0);
      comprobar("reset_datain", Datain, 32'h0);
      comprobar("reset_direc", {24'h0, Direc}, 32'h0);

      // directed table
      for (int i = 0; i < 13; i++) begin
         ejecutar($sformatf("tabla%0d", i), tabla[i].escr, tabla[i].tam, tabla[i].sin,
                  tabla[i].dir, tabla[i].dato);
         comprobar($sformatf("tabla%0d_const_leido", i), r_leido, tabla[i].leido);
         comprobar($sformatf("tabla%0d_const_lat", i), r_lat, tabla[i].lat);
         comprobar($sformatf("tabla%0d_const_err", i), {31'h0, r_err}, {31'h0, tabla[i].err});
         if (tabla[i].escr && !tabla[i].err)
            comprobar($sformatf("tabla%0d_const_datain", i), r_datain, tabla[i].datain);
      end

      // random requests
      for (int i = 0; i < 150; i++) begin
         r_escr = 1'($urandom_range(0, 1));
         r_sin  = 1'($urandom_range(0, 1));
         r_tam  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         r_dir  = 10'($urandom_range(0, 63));
         nb     = (r_tam == 2'd0) ? 1 : (r_tam == 2'd1) ? 2 : 4;
         if ($urandom_range(0, 3) != 0) r_dir = r_dir & ~10'(nb - 1);
         ejecutar($sformatf("rnd%0d", i), r_escr, r_tam, r_sin, r_dir, $urandom);
      end

      // reset in the middle of a sub-word store
      ejecutar("pre_rst", 1'b1, 2'b10, 1'b0, 10'h00C, 32'h55667788);
      Inicio = 1'b1; Escr = 1'b1; Tam = 2'b00; SinSigno = 1'b0; DirecByte = 10'h00D; DatoEscr = 32'h00000099;
      @(negedge clk);
      Inicio = 1'b0;
      comprobar("rst_leer", {31'h0, LeerMem}, 32'h1);
      @(negedge clk);
      comprobar("rst_escr_activo", {31'h0, EscrMem}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      comprobar("rst_escr_cae", {31'h0, EscrMem}, 32'h0);
      comprobar("rst_ctrl", {27'h0, Ocupado, Listo, ErrAlin, LeerMem, EscrMem}, 32'h0);
      comprobar("rst_leido", DatoLeido, 32'h0);
      comprobar("rst_datain", Datain, 32'h0);
      comprobar("rst_direc", {24'h0, Direc}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      last_leido = 32'h0; n_cargas = 0; n_almac = 0;
      @(negedge clk);
      comprobar("rst_mem_intacta", mem[3], 32'h55667788);
      ejecutar("post_rst", 1'b0, 2'b10, 1'b0, 10'h00C, 32'h0);

      // Inicio held high while busy, with other fields changing
      modelo(1'b1, 2'b01, 1'b0, 10'h00E, 32'h0000CAFE);
      Inicio = 1'b1; Escr = 1'b1; Tam = 2'b01; SinSigno = 1'b0; DirecByte = 10'h00E; DatoEscr = 32'h0000CAFE;
      @(negedge clk);
      comprobar("ocupado_activo", {31'h0, Ocupado}, 32'h1);
      Escr = 1'b0; Tam = 2'b10; DirecByte = 10'h010; DatoEscr = 32'h12345678;
      esperar_fin();
      Inicio = 1'b0;
      comparar("ocupado", 10'h00E);
      @(negedge clk);
      comprobar("ocupado_sin_extra", {30'h0, LeerMem, EscrMem}, 32'h0);
      ejecutar("ocupado_lectura", 1'b0, 2'b10, 1'b0, 10'h00C, 32'h0);
      comprobar("ocupado_palabra", r_leido, 32'hCAFE7788);

      // final memory image against the model
      for (int i = 0; i < 16; i++) comprobar($sformatf("mem%0d", i), mem[i], ref_mem[i]);

`ifdef CONTADORES_ACCESO_EN
      comprobar("num_cargas", {16'h0, NumCargas}, 32'(n_cargas));
      comprobar("num_almac", {16'h0, NumAlmac}, 32'(n_almac));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
